// File: rtl/configure.sv
// Shared memory-system configuration: RAM geometry/latency and the RAM request payload.
package configure;

  localparam int unsigned addr_w    = 32;
  localparam int unsigned data_w    = 32;
  localparam int unsigned strb_w    = 4;
  localparam int unsigned ram_depth = 1024;
  localparam int unsigned ram_cycle = 2;

  typedef struct packed {
    logic [addr_w-1:0] addr;
    logic [data_w-1:0] wdata;
    logic [strb_w-1:0] wstrb;
    logic              instr;
  } ram_req_t;

  typedef enum logic {
    st_idle = 1'b0,
    st_busy = 1'b1
  } arb_state_t;

  typedef enum logic {
    own_i = 1'b0,
    own_d = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/ram_arbiter_slot.sv
// One pending-request slot: latches a valid pulse, clears on completion, reloads if both coincide.
module ram_arbiter_slot
  import configure::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     valid,
  input  ram_req_t req_in,
  input  logic     done,
  output logic     avail_c,
  output ram_req_t req_c
);

  logic     pend_q;
  ram_req_t req_q;
  logic     accept_c;

  // A new pulse is taken when the slot is free or is being freed this cycle.
  assign accept_c = valid & (~pend_q | done);
  assign avail_c  = accept_c | (pend_q & ~done);
  assign req_c    = accept_c ? req_in : req_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_q <= 1'b0;
      req_q  <= '0;
    end else begin
      pend_q <= avail_c;
      if (accept_c) req_q <= req_in;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-ported RAM between the fetch (imem) and load/store (dmem) ports.
// Contention policy: fixed dmem priority, or round-robin when RAM_ARB_RR_EN is defined.
module ram_arbiter
  import configure::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              imem_valid,
  input  logic [addr_w-1:0] imem_addr,
  output logic [data_w-1:0] imem_rdata,
  output logic              imem_ready,
  input  logic              dmem_valid,
  input  logic [addr_w-1:0] dmem_addr,
  input  logic [data_w-1:0] dmem_wdata,
  input  logic [strb_w-1:0] dmem_wstrb,
  output logic [data_w-1:0] dmem_rdata,
  output logic              dmem_ready,
  output logic              ram_valid,
  output logic              ram_instr,
  output logic [addr_w-1:0] ram_addr,
  output logic [data_w-1:0] ram_wdata,
  output logic [strb_w-1:0] ram_wstrb,
  input  logic [data_w-1:0] ram_rdata,
  input  logic              ram_ready
);

  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;
  ram_req_t   ram_req_q, ram_req_d;
  ram_req_t   imem_in, dmem_in;
  ram_req_t   ireq_c, dreq_c;
  logic       avail_i_c, avail_d_c;
  logic       resp_c, done_i_c, done_d_c, pick_d_c;

  assign imem_in = '{addr: imem_addr, wdata: '0, wstrb: '0, instr: 1'b1};
  assign dmem_in = '{addr: dmem_addr, wdata: dmem_wdata, wstrb: dmem_wstrb, instr: 1'b0};

  // Responses only count while a grant is outstanding.
  assign resp_c   = (state_q == st_busy) & ram_ready;
  assign done_i_c = resp_c & (owner_q == own_i);
  assign done_d_c = resp_c & (owner_q == own_d);

  ram_arbiter_slot u_slot_i (
    .clock   (clock),
    .reset   (reset),
    .valid   (imem_valid),
    .req_in  (imem_in),
    .done    (done_i_c),
    .avail_c (avail_i_c),
    .req_c   (ireq_c)
  );

  ram_arbiter_slot u_slot_d (
    .clock   (clock),
    .reset   (reset),
    .valid   (dmem_valid),
    .req_in  (dmem_in),
    .done    (done_d_c),
    .avail_c (avail_d_c),
    .req_c   (dreq_c)
  );

`ifdef RAM_ARB_RR_EN
  arb_owner_t last_q;

  // On a tie the port not served last wins.
  assign pick_d_c = avail_d_c & (~avail_i_c | (last_q == own_i));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) last_q <= own_i;
    else        last_q <= owner_d;
  end
`else
  assign pick_d_c = avail_d_c;
`endif

  // Next-state: grant from IDLE or on the completion edge of the current access.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ram_req_d = ram_req_q;
    if ((state_q == st_idle) || resp_c) begin
      if (avail_i_c || avail_d_c) begin
        state_d   = st_busy;
        owner_d   = pick_d_c ? own_d : own_i;
        ram_req_d = pick_d_c ? dreq_c : ireq_c;
      end else begin
        state_d = st_idle;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= st_idle;
      owner_q   <= own_i;
      ram_req_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ram_req_q <= ram_req_d;
    end
  end

  // Request is withdrawn in the response cycle so the RAM never repeats it.
  assign ram_valid  = (state_q == st_busy) & ~ram_ready;
  assign ram_instr  = ram_req_q.instr;
  assign ram_addr   = ram_req_q.addr;
  assign ram_wdata  = ram_req_q.wdata;
  assign ram_wstrb  = ram_req_q.wstrb;

  assign imem_ready = done_i_c;
  assign dmem_ready = done_d_c;
  assign imem_rdata = done_i_c ? ram_rdata : '0;
  assign dmem_rdata = done_d_c ? ram_rdata : '0;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-ported `ram` model between the instruction-fetch port (`imem`) and the load/store port (`dmem`).
- Each port issues a one-cycle request pulse; the arbiter latches it into a per-port pending slot.
- It grants one slot at a time and holds the RAM request until `ram_ready`.
- It steers `ram_ready`/`ram_rdata` back to the owning port.
- It sits between the core's memory ports and `ram` in the testbench/SoC top.

## Interface
Parameters:
- None. Address and data are 32 bits; the write strobe is 4 bits.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `imem_valid`  in  1  fetch request pulse (one cycle).
- `imem_addr`  in  32  fetch address.
- `imem_rdata`  out  32  fetch data; valid while `imem_ready`=1.
- `imem_ready`  out  1  fetch completion pulse.
- `dmem_valid`  in  1  data request pulse (one cycle).
- `dmem_addr`  in  32  data address.
- `dmem_wdata`  in  32  store data.
- `dmem_wstrb`  in  4  byte strobes; 0 means a load.
- `dmem_rdata`  out  32  load data; valid while `dmem_ready`=1.
- `dmem_ready`  out  1  data completion pulse.
- `ram_valid`, `ram_instr`, `ram_addr`[32], `ram_wdata`[32], `ram_wstrb`[4]  out  request to `ram`.
- `ram_rdata`[32], `ram_ready`[1]  in  response from `ram`.

## Operation
- **Pending slot per port.**
  - Fields: `{pend, addr, wdata, wstrb}`. The imem slot forces `wstrb`=0 and `wdata`=0.
  - Set on a clock edge where `*_valid`=1. Cleared on the edge where that port's grant completes.
  - One outstanding request per port. A `*_valid` while that slot is pending is ignored unless the same cycle is its completion cycle; in that case the new request is latched.
- **FSM states:** IDLE, BUSY. A 1-bit `owner` register holds I or D.
- **IDLE:**
  - If any slot is pending, or a `*_valid` arrives this cycle (bypass), go to BUSY.
  - Load the `ram_*` request registers from the chosen request. Set `owner`.
- **BUSY:**
  - `ram_valid` = BUSY & !`ram_ready`. The request is withdrawn combinationally in the response cycle so `ram` never re-executes it.
  - On `ram_ready`=1, pass it through combinationally:
    - owner=I: `imem_ready`=1, `imem_rdata`=`ram_rdata`.
    - owner=D: `dmem_ready`=1, `dmem_rdata`=`ram_rdata`.
  - At that edge, clear the owner's slot. If the other slot is pending (or a new request arrives), re-grant immediately (BUSY→BUSY). Otherwise go to IDLE.
- `ram_instr` = (owner==I).
- `*_rdata` = 0 whenever the corresponding `*_ready` = 0.
- `ram_ready` seen in IDLE (e.g. a response after reset) is ignored; no port ready is raised.
- **Arbitration on contention:** fixed priority, dmem over imem (default build). See Configuration.

## Timing
- **Reset** (asynchronous assert):
  - state=IDLE, `owner`=I, both slots cleared.
  - `ram_valid`/`ram_instr`/`ram_addr`/`ram_wdata`/`ram_wstrb`=0.
  - `imem_ready`=`dmem_ready`=0; `*_rdata`=0.
- **Reset mid-transaction:** the in-flight request is dropped. No ready is issued for it. A stale `ram_ready` afterwards is ignored.
- **Latency** (`ram_cycle`=N), from `*_valid` in cycle 0 with the arbiter IDLE:
  - `ram_valid` high cycles 1..N+1.
  - `*_ready` in cycle N+2.
- **Back-to-back:** a second granted request drives `ram_valid` in the cycle after the previous `ram_ready`, giving one bubble between accesses.
- **Simultaneous `imem_valid` and `dmem_valid` in IDLE:** the arbitration rule picks one. The loser stays pending and is granted on the winner's completion edge.

## Configuration
- `RAM_ARB_RR_EN` defined:
  - Round-robin on contention. The grant goes to the port not served last, tracked in a `last` register (reset = I, so dmem wins the first tie).
  - Either port waits at most one foreign transaction.
- Not defined:
  - Fixed dmem priority. imem can starve under continuous dmem traffic, which is acceptable for the in-order core.

## Structure
- Shared package `configure` holds `ram_depth`, `ram_cycle`, and the new typedef `ram_req_t {addr, wdata, wstrb, instr}`.
- Sub-module `ram_arbiter_slot`: one pending slot with its set/clear/simultaneous-reload logic. It is instantiated twice.
- The FSM, grant selection and response steering stay in `ram_arbiter`.

## Test plan
- **Single fetch, `ram_cycle`=2.** `imem_valid` at cycle 0, addr 0x00000010 → `ram_valid`/`ram_instr`=1 cycles 1–3; `imem_ready` at cycle 4 with `ram_block[4]`.
- **Store then load.** `dmem` store addr 0x20, wdata 0xDEADBEEF, wstrb 0xF; then load 0x20 → `dmem_rdata`=0xDEADBEEF. The memory is written exactly once (check with `ram_cycle`=0).
- **Collision, default build.** imem and dmem valid in the same cycle → dmem served first, imem granted on dmem's ready edge, `imem_ready` N+2 cycles later.
- **Collision with `RAM_ARB_RR_EN`.** 4 simultaneous request pairs → grants alternate D, I, D, I…; neither port waits more than one foreign access.
- **Reset mid-operation.** Pulse `reset` low while BUSY → all outputs 0 immediately; no `*_ready` follows. A new fetch after release completes normally.
- **Reload on completion.** A new `dmem_valid` in the same cycle as `dmem_ready` → latched and granted; no request lost or duplicated.
